// File: rtl/alu_issue_pkg.sv
// Shared types for the ALU issue stage: decoded instruction format,
// the trimmed entry held in the issue buffer, and operand-usage helpers.
package alu_issue_pkg;

    localparam int REG_COUNT = 32;

    typedef enum logic [1:0] {
        INSTR_OP     = 2'd0,
        INSTR_OP_IMM = 2'd1,
        INSTR_NONE   = 2'd2
    } instr_kind_e;

    typedef struct packed {
        instr_kind_e kind;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
    } decoded_instr;

    // Buffered form: operand values are resolved at issue time, so they are not stored.
    typedef struct packed {
        instr_kind_e kind;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } issue_entry;

    function automatic issue_entry to_entry(input decoded_instr d);
        issue_entry e;
        e.kind   = d.kind;
        e.rd     = d.rd;
        e.rs1    = d.rs1;
        e.rs2    = d.rs2;
        e.funct3 = d.funct3;
        e.funct7 = d.funct7;
        e.imm    = d.imm;
        return e;
    endfunction

    // rs1 is read by both register and immediate forms.
    function automatic logic uses_rs1(input instr_kind_e k);
        return (k == INSTR_OP) || (k == INSTR_OP_IMM);
    endfunction

    // For immediate forms the rs2 field holds immediate bits, not a register.
    function automatic logic uses_rs2(input instr_kind_e k);
        return (k == INSTR_OP);
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Decoupled valid/ready channel carrying one decoded instruction.
interface alu_issue_if;
    import alu_issue_pkg::*;

    logic         valid;
    logic         ready;
    decoded_instr data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/alu_issue_scoreboard.sv
// Scoreboard of registers with an in-flight writer. A set and a clear of the
// same index in one cycle leaves the bit set (the new writer is younger).
// x0 is never marked pending.
module scoreboard
    import alu_issue_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_en,
    input  logic [4:0]           set_idx,
    input  logic                 clr_en,
    input  logic [4:0]           clr_idx,
    input  logic                 flush,
    output logic [REG_COUNT-1:0] pending
);

    logic [REG_COUNT-1:0] pending_next;

    // Apply clear first so a same-index set overrides it; then pin x0 low.
    always_comb begin
        pending_next = pending;
        if (clr_en) begin
            pending_next[clr_idx] = 1'b0;
        end
        if (set_en) begin
            pending_next[set_idx] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    // Pending mask register; flush squashes everything, including this cycle's writeback.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
        end else if (flush) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// Issue stage in front of the integer ALU: 2-entry instruction buffer,
// register file read from the head entry, RAW hazard stall against a
// pending-writer scoreboard, and operand resolution.
// Build option: define ALU_ISSUE_BYPASS_EN to forward the writeback value
// to a waiting consumer in the same cycle; otherwise the consumer waits for
// the register file to be written.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    alu_issue_if.slave  decoded,
    alu_issue_if.master issued,
    output logic [4:0]  rf_rs1_idx,
    input  logic [31:0] rf_rs1_val,
    output logic [4:0]  rf_rs2_idx,
    input  logic [31:0] rf_rs2_val,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd_idx,
    input  logic [31:0] wb_rd_val,
    input  logic        flush
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    issue_entry           head_q;
    issue_entry           tail_q;
    logic [CNT_W-1:0]     count_q;
    logic                 empty;
    logic                 full;
    logic                 enq;
    logic                 deq;
    issue_entry           incoming;
    logic [REG_COUNT-1:0] pending;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic                 byp1;
    logic                 byp2;
    logic                 hazard;
    logic [31:0]          rs1_val;
    logic [31:0]          rs2_val;
    decoded_instr         out_instr;
    logic                 unused_in_vals;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign incoming = to_entry(decoded.data);

    // Incoming operand values are recomputed here, so those fields are dropped.
    assign unused_in_vals = ^{decoded.data.rs1_val, decoded.data.rs2_val};

    assign decoded.ready = !full && !flush;
    assign enq           = decoded.valid && decoded.ready;
    assign deq           = issued.valid && issued.ready;

    // FIFO of two slots kept as head/tail registers; the tail shifts into the head on dequeue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            count_q <= '0;
        end else begin
            case ({enq, deq})
                2'b10: begin
                    if (empty) begin
                        head_q <= incoming;
                    end else begin
                        tail_q <= incoming;
                    end
                    count_q <= count_q + CNT_W'(1);
                end
                2'b01: begin
                    head_q  <= tail_q;
                    count_q <= count_q - CNT_W'(1);
                end
                2'b11: begin
                    head_q <= incoming;
                end
                default: begin
                end
            endcase
        end
    end

    assign rs1        = head_q.rs1;
    assign rs2        = head_q.rs2;
    assign rf_rs1_idx = rs1;
    assign rf_rs2_idx = rs2;

`ifdef ALU_ISSUE_BYPASS_EN
    assign byp1 = wb_valid && (wb_rd_idx == rs1);
    assign byp2 = wb_valid && (wb_rd_idx == rs2);
`else
    logic unused_wb_val;
    assign byp1          = 1'b0;
    assign byp2          = 1'b0;
    assign unused_wb_val = ^wb_rd_val;
`endif

    // Stall while any used source has an in-flight writer not being forwarded this cycle.
    always_comb begin
        hazard = 1'b0;
        if (uses_rs1(head_q.kind) && pending[rs1] && (rs1 != 5'd0) && !byp1) begin
            hazard = 1'b1;
        end
        if (uses_rs2(head_q.kind) && pending[rs2] && (rs2 != 5'd0) && !byp2) begin
            hazard = 1'b1;
        end
    end

    // Operand selection: x0 reads zero, then forwarded writeback, then register file.
    always_comb begin
        rs1_val = rf_rs1_val;
        rs2_val = rf_rs2_val;
`ifdef ALU_ISSUE_BYPASS_EN
        if (byp1) begin
            rs1_val = wb_rd_val;
        end
        if (byp2) begin
            rs2_val = wb_rd_val;
        end
`endif
        if (rs1 == 5'd0) begin
            rs1_val = '0;
        end
        if (rs2 == 5'd0) begin
            rs2_val = '0;
        end
    end

    // Assemble the outgoing instruction from the head entry and resolved operands.
    always_comb begin
        out_instr         = '0;
        out_instr.kind    = head_q.kind;
        out_instr.rd      = head_q.rd;
        out_instr.rs1     = head_q.rs1;
        out_instr.rs2     = head_q.rs2;
        out_instr.funct3  = head_q.funct3;
        out_instr.funct7  = head_q.funct7;
        out_instr.imm     = head_q.imm;
        out_instr.rs1_val = rs1_val;
        out_instr.rs2_val = rs2_val;
    end

    assign issued.valid = !empty && !hazard && !flush;
    assign issued.data  = out_instr;

    scoreboard u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .set_en  (deq && (head_q.rd != 5'd0)),
        .set_idx (head_q.rd),
        .clr_en  (wb_valid),
        .clr_idx (wb_rd_idx),
        .flush   (flush),
        .pending (pending)
    );

endmodule

// File: tb/tb_alu_issue.sv
// Directed testbench for alu_issue with a behavioural register file.
// Expected values cover both the bypass and non-bypass builds.
module tb_alu_issue;
    import alu_issue_pkg::*;

`ifdef ALU_ISSUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  rf_rs1_idx;
    logic [31:0] rf_rs1_val;
    logic [4:0]  rf_rs2_idx;
    logic [31:0] rf_rs2_val;
    logic        wb_valid;
    logic [4:0]  wb_rd_idx;
    logic [31:0] wb_rd_val;
    logic        flush;
    logic [31:0] rf [REG_COUNT];

    int errors = 0;
    int checks = 0;

    alu_issue_if decoded_bus ();
    alu_issue_if issued_bus ();

    alu_issue dut (
        .clk        (clk),
        .rst        (rst),
        .decoded    (decoded_bus),
        .issued     (issued_bus),
        .rf_rs1_idx (rf_rs1_idx),
        .rf_rs1_val (rf_rs1_val),
        .rf_rs2_idx (rf_rs2_idx),
        .rf_rs2_val (rf_rs2_val),
        .wb_valid   (wb_valid),
        .wb_rd_idx  (wb_rd_idx),
        .wb_rd_val  (wb_rd_val),
        .flush      (flush)
    );

    always #5 clk = ~clk;

    // Register file model: known contents during reset, written at the end of a writeback cycle.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                rf[i] <= (i == 0) ? 32'hDEAD_BEEF : (32'h0000_1000 | 32'(i));
            end
        end else if (wb_valid) begin
            rf[wb_rd_idx] <= wb_rd_val;
        end
    end

    assign rf_rs1_val = rf[rf_rs1_idx];
    assign rf_rs2_val = rf[rf_rs2_idx];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic v, input decoded_instr d);
        decoded_bus.valid = v;
        decoded_bus.data  = d;
    endtask

    task automatic set_wb(input logic v, input logic [4:0] idx, input logic [31:0] val);
        wb_valid  = v;
        wb_rd_idx = idx;
        wb_rd_val = val;
    endtask

    function automatic decoded_instr mk_add(input logic [4:0] rd, input logic [4:0] s1, input logic [4:0] s2);
        decoded_instr d;
        d         = '0;
        d.kind    = INSTR_OP;
        d.rd      = rd;
        d.rs1     = s1;
        d.rs2     = s2;
        d.rs1_val = 32'hBAD0_0001;
        d.rs2_val = 32'hBAD0_0002;
        return d;
    endfunction

    function automatic decoded_instr mk_addi(input logic [4:0] rd, input logic [4:0] s1, input logic [11:0] imm);
        decoded_instr d;
        d         = '0;
        d.kind    = INSTR_OP_IMM;
        d.rd      = rd;
        d.rs1     = s1;
        d.rs2     = imm[4:0];
        d.imm     = {{20{imm[11]}}, imm};
        d.rs1_val = 32'hBAD0_0003;
        d.rs2_val = 32'hBAD0_0004;
        return d;
    endfunction

    initial begin
        int          head_cyc;
        int          acc_cyc;
        logic [31:0] head_rs1;
        logic [4:0]  order [$];

        apply_stimulus(1'b0, '0);
        set_wb(1'b0, 5'd0, 32'd0);
        flush            = 1'b0;
        issued_bus.ready = 1'b1;

        // Power-on reset
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check_output("rst_valid", issued_bus.valid, 1'b0);
        check_output("rst_ready", decoded_bus.ready, 1'b1);
        check_output("rst_pending", dut.pending, 32'h0);

        // Independent stream: ADDI x1,x0,5 ; ADDI x2,x0,7
        tick();
        apply_stimulus(1'b1, mk_addi(5'd1, 5'd0, 12'd5));
        #1;
        check_output("a0_ready", decoded_bus.ready, 1'b1);
        check_output("a0_no_passthru", issued_bus.valid, 1'b0);
        tick();
        apply_stimulus(1'b1, mk_addi(5'd2, 5'd0, 12'd7));
        #1;
        check_output("a1_valid", issued_bus.valid, 1'b1);
        check_output("a1_rd", issued_bus.data.rd, 5'd1);
        check_output("a1_rs1_x0", issued_bus.data.rs1_val, 32'h0);
        tick();
        decoded_bus.valid = 1'b0;
        #1;
        check_output("a2_valid", issued_bus.valid, 1'b1);
        check_output("a2_rd", issued_bus.data.rd, 5'd2);
        check_output("a2_rs1_x0", issued_bus.data.rs1_val, 32'h0);
        check_output("a2_pending", dut.pending, 32'h0000_0002);

        // RAW: ADD x3,x1,x2 with x2 written back now and x1 two cycles later
        tick();
        apply_stimulus(1'b1, mk_add(5'd3, 5'd1, 5'd2));
        set_wb(1'b1, 5'd2, 32'h0000_0022);
        #1;
        check_output("b0_valid", issued_bus.valid, 1'b0);
        check_output("b0_pending", dut.pending, 32'h0000_0006);
        tick();
        decoded_bus.valid = 1'b0;
        set_wb(1'b0, 5'd0, 32'd0);
        #1;
        check_output("b1_stall", issued_bus.valid, 1'b0);
        check_output("b1_pending", dut.pending, 32'h0000_0002);
        tick();
        set_wb(1'b1, 5'd1, 32'h1234_5678);
        #1;
        check_output("b2_valid", issued_bus.valid, BYP);
        check_output("b2_rs1", issued_bus.data.rs1_val, BYP ? 32'h1234_5678 : 32'h0000_1001);
        check_output("b2_rs2", issued_bus.data.rs2_val, 32'h0000_0022);
        tick();
        set_wb(1'b0, 5'd0, 32'd0);
        #1;
        check_output("b3_valid", issued_bus.valid, !BYP);
        check_output("b3_pending", dut.pending, BYP ? 32'h0000_0008 : 32'h0000_0000);
`ifndef ALU_ISSUE_BYPASS_EN
        check_output("b3_rs1_rf", issued_bus.data.rs1_val, 32'h1234_5678);
        check_output("b3_rs2_rf", issued_bus.data.rs2_val, 32'h0000_0022);
`endif
        tick();
        check_output("b4_valid", issued_bus.valid, 1'b0);
        check_output("b4_pending", dut.pending, 32'h0000_0008);

        // I-type: ADDI x4,x5,1 whose rs2 field (=1) names a pending register
        tick();
        apply_stimulus(1'b1, mk_addi(5'd1, 5'd0, 12'd9));
        tick();
        apply_stimulus(1'b1, mk_addi(5'd4, 5'd5, 12'd1));
        #1;
        check_output("c0_valid", issued_bus.valid, 1'b1);
        check_output("c0_rd", issued_bus.data.rd, 5'd1);
        tick();
        decoded_bus.valid = 1'b0;
        #1;
        check_output("c1_pending", dut.pending, 32'h0000_000A);
        check_output("c1_no_stall", issued_bus.valid, 1'b1);
        check_output("c1_rd", issued_bus.data.rd, 5'd4);
        check_output("c1_rs1", issued_bus.data.rs1_val, 32'h0000_1005);
        tick();
        check_output("c2_pending", dut.pending, 32'h0000_001A);
        check_output("c2_valid", issued_bus.valid, 1'b0);

        // Full buffer: ADD x5,x4,x0 stalls on x4; offer ADDI x6 and ADDI x7
        tick();
        apply_stimulus(1'b1, mk_add(5'd5, 5'd4, 5'd0));
        tick();
        apply_stimulus(1'b1, mk_addi(5'd6, 5'd0, 12'd1));
        #1;
        check_output("d0_ready", decoded_bus.ready, 1'b1);
        check_output("d0_stall", issued_bus.valid, 1'b0);
        tick();
        apply_stimulus(1'b1, mk_addi(5'd7, 5'd0, 12'd2));
        set_wb(1'b1, 5'd4, 32'h0000_0044);
        #1;
        check_output("d1_full", decoded_bus.ready, 1'b0);
        head_cyc = -1;
        acc_cyc  = -1;
        head_rs1 = '0;
        for (int k = 0; k < 6; k++) begin
            if (issued_bus.valid && issued_bus.ready) begin
                if (order.size() == 0) begin
                    head_cyc = k;
                    head_rs1 = issued_bus.data.rs1_val;
                end
                order.push_back(issued_bus.data.rd);
            end
            if (decoded_bus.valid && decoded_bus.ready) begin
                acc_cyc = k;
            end
            tick();
            if (acc_cyc >= 0) begin
                decoded_bus.valid = 1'b0;
            end
            set_wb(1'b0, 5'd0, 32'd0);
            #1;
        end
        check_output("d2_head_cycle", 32'(head_cyc), BYP ? 32'd0 : 32'd1);
        check_output("d2_accept_cycle", 32'(acc_cyc), BYP ? 32'd1 : 32'd2);
        check_output("d2_head_rs1", head_rs1, 32'h0000_0044);
        check_output("d2_issue_count", 32'(order.size()), 32'd3);
        if (order.size() >= 3) begin
            check_output("d2_order0", 32'(order[0]), 32'd5);
            check_output("d2_order1", 32'(order[1]), 32'd6);
            check_output("d2_order2", 32'(order[2]), 32'd7);
        end
        check_output("d2_pending", dut.pending, 32'h0000_00EA);

        // Flush: clear, rebuild pending=0xE with two stalled entries, flush again
        flush = 1'b1;
        #1;
        check_output("e0_ready", decoded_bus.ready, 1'b0);
        check_output("e0_valid", issued_bus.valid, 1'b0);
        tick();
        flush = 1'b0;
        #1;
        check_output("e1_pending", dut.pending, 32'h0);
        apply_stimulus(1'b1, mk_addi(5'd1, 5'd0, 12'd1));
        tick();
        apply_stimulus(1'b1, mk_addi(5'd2, 5'd0, 12'd2));
        tick();
        apply_stimulus(1'b1, mk_addi(5'd3, 5'd0, 12'd3));
        tick();
        apply_stimulus(1'b1, mk_add(5'd8, 5'd1, 5'd0));
        tick();
        apply_stimulus(1'b1, mk_add(5'd9, 5'd1, 5'd0));
        tick();
        decoded_bus.valid = 1'b0;
        #1;
        check_output("e2_ready", decoded_bus.ready, 1'b0);
        check_output("e2_stall", issued_bus.valid, 1'b0);
        check_output("e2_pending", dut.pending, 32'h0000_000E);
        flush = 1'b1;
        apply_stimulus(1'b1, mk_addi(5'd11, 5'd0, 12'd0));
        #1;
        check_output("e3_ready", decoded_bus.ready, 1'b0);
        check_output("e3_valid", issued_bus.valid, 1'b0);
        tick();
        flush             = 1'b0;
        decoded_bus.valid = 1'b0;
        #1;
        check_output("e4_valid", issued_bus.valid, 1'b0);
        check_output("e4_pending", dut.pending, 32'h0);
        check_output("e4_ready", decoded_bus.ready, 1'b1);
        apply_stimulus(1'b1, mk_addi(5'd10, 5'd0, 12'd3));
        #1;
        check_output("e4_no_passthru", issued_bus.valid, 1'b0);
        tick();
        decoded_bus.valid = 1'b0;
        issued_bus.ready  = 1'b0;
        #1;
        check_output("e5_valid", issued_bus.valid, 1'b1);
        check_output("e5_rd", issued_bus.data.rd, 5'd10);
        check_output("e5_rs1_x0", issued_bus.data.rs1_val, 32'h0);
        tick();
        check_output("e6_valid_hold", issued_bus.valid, 1'b1);
        check_output("e6_rd_hold", issued_bus.data.rd, 5'd10);
        check_output("e6_pending_noset", dut.pending, 32'h0);
        issued_bus.ready = 1'b1;
        tick();
        check_output("e7_pending", dut.pending, 32'h0000_0400);
        check_output("e7_valid", issued_bus.valid, 1'b0);

        // Reset mid-stream with two stalled entries buffered
        apply_stimulus(1'b1, mk_add(5'd12, 5'd10, 5'd0));
        tick();
        apply_stimulus(1'b1, mk_add(5'd13, 5'd10, 5'd0));
        tick();
        decoded_bus.valid = 1'b0;
        #1;
        check_output("f0_ready", decoded_bus.ready, 1'b0);
        rst = 1'b0;
        #1;
        check_output("f1_valid", issued_bus.valid, 1'b0);
        check_output("f1_pending", dut.pending, 32'h0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check_output("f2_ready", decoded_bus.ready, 1'b1);
        check_output("f2_valid", issued_bus.valid, 1'b0);
        check_output("f2_pending", dut.pending, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
